// File: rtl/clkdiv_rst_seq.sv
// Reset/calibration sequencer for the Gowin CLKDIV /2 stage: qualifies PLL lock,
// sequences the divider's resetn and CALIB pins, and flags when the divided clock is usable.
module clkdiv_rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int SETTLE_CYCLES      = 32,
  parameter int CALIB_CYCLES       = 2
) (
  input  logic       hclkin,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       calib_req,
  output logic       clkdiv_resetn,
  output logic       clkdiv_calib,
  output logic       div_ready,
  output logic [2:0] state,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int MAX_CD = (SETTLE_CYCLES > CALIB_CYCLES) ? SETTLE_CYCLES : CALIB_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CALIB_LAST  = CW'(CALIB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_HOLD      = 3'd1,
    S_SETTLE    = 3'd2,
    S_READY     = 3'd3,
    S_CALIB     = 3'd4
  } state_t;

  logic          lock_meta_q, lock_meta_d;
  logic          lock_sync_q, lock_sync_d;
  logic          cal_meta_q, cal_meta_d;
  logic          cal_sync_q, cal_sync_d;
  logic          cal_dly_q, cal_dly_d;
  logic          cal_rise_q, cal_rise_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    llc_q, llc_d;
  logic          resetn_q, resetn_d;
  logic          calib_q, calib_d;
  logic          ready_q, ready_d;

  // Input conditioning: two-flop synchronizers plus a registered rising-edge detect on calib_req.
  always_comb begin
    lock_meta_d = pll_lock;
    lock_sync_d = lock_meta_q;
    cal_meta_d  = calib_req;
    cal_sync_d  = cal_meta_q;
    cal_dly_d   = cal_sync_q;
    cal_rise_d  = cal_sync_q & ~cal_dly_q;
  end

  // Next-state and counter logic; lock loss outranks a calibration request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    llc_d   = llc_q;
    case (state_q)
      S_WAIT_LOCK: begin
        if (!lock_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD, S_SETTLE, S_READY, S_CALIB: begin
        if (!lock_sync_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          if (llc_q != 8'hFF) begin
            llc_d = llc_q + 8'd1;
          end else begin
            llc_d = llc_q;
          end
        end else if (state_q == S_HOLD && cnt_q == HOLD_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (state_q == S_SETTLE && cnt_q == SETTLE_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else if (state_q == S_CALIB && cnt_q == CALIB_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (state_q == S_READY) begin
          // READY is untimed: park the counter so it never wraps.
          cnt_d = '0;
          if (cal_rise_q) begin
            state_d = S_CALIB;
          end else begin
            state_d = S_READY;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register on the same edge as the state.
  always_comb begin
    resetn_d = 1'b0;
    calib_d  = 1'b0;
    ready_d  = 1'b0;
    case (state_d)
      S_WAIT_LOCK: begin resetn_d = 1'b0; calib_d = 1'b0; ready_d = 1'b0; end
      S_HOLD:      begin resetn_d = 1'b0; calib_d = 1'b0; ready_d = 1'b0; end
      S_SETTLE:    begin resetn_d = 1'b1; calib_d = 1'b0; ready_d = 1'b0; end
      S_READY:     begin resetn_d = 1'b1; calib_d = 1'b0; ready_d = 1'b1; end
      S_CALIB:     begin resetn_d = 1'b1; calib_d = 1'b1; ready_d = 1'b0; end
      default:     begin resetn_d = 1'b0; calib_d = 1'b0; ready_d = 1'b0; end
    endcase
  end

  // State, counter, synchronizer and output registers.
  always_ff @(posedge hclkin or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      cal_meta_q  <= 1'b0;
      cal_sync_q  <= 1'b0;
      cal_dly_q   <= 1'b0;
      cal_rise_q  <= 1'b0;
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= '0;
      llc_q       <= 8'd0;
      resetn_q    <= 1'b0;
      calib_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      cal_meta_q  <= cal_meta_d;
      cal_sync_q  <= cal_sync_d;
      cal_dly_q   <= cal_dly_d;
      cal_rise_q  <= cal_rise_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      llc_q       <= llc_d;
      resetn_q    <= resetn_d;
      calib_q     <= calib_d;
      ready_q     <= ready_d;
    end
  end

  assign clkdiv_resetn = resetn_q;
  assign clkdiv_calib  = calib_q;
  assign div_ready     = ready_q;
  assign state         = state_q;
  assign lock_lost_cnt = llc_q;

endmodule

// File: tb/tb_clkdiv_rst_seq.sv
// Self-checking bench for clkdiv_rst_seq: timed expectations queued at stimulus time,
// popped and compared on the falling edge when their cycle arrives.
module tb_clkdiv_rst_seq;

  localparam int LSC = 8;
  localparam int RHC = 4;
  localparam int SC  = 4;
  localparam int CC  = 2;

  logic       hclkin = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       calib_req;
  logic       clkdiv_resetn;
  logic       clkdiv_calib;
  logic       div_ready;
  logic [2:0] state;
  logic [7:0] lock_lost_cnt;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         off;
    logic       rn;
    logic       ca;
    logic       rd;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    int         cyc;
    string      nm;
    logic       rn;
    logic       ca;
    logic       rd;
    logic [2:0] st;
    int         llc;
  } exp_t;

  exp_t sb[$];
  vec_t acq[7];
  vec_t cal[6];

  clkdiv_rst_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .RESET_HOLD_CYCLES (RHC),
    .SETTLE_CYCLES     (SC),
    .CALIB_CYCLES      (CC)
  ) dut (
    .hclkin       (hclkin),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .calib_req    (calib_req),
    .clkdiv_resetn(clkdiv_resetn),
    .clkdiv_calib (clkdiv_calib),
    .div_ready    (div_ready),
    .state        (state),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 hclkin = ~hclkin;

  always @(posedge hclkin) cyc <= cyc + 1;

  task automatic push(input int c, input string nm, input logic rn, input logic ca,
                      input logic rd, input logic [2:0] st, input int llc);
    exp_t e;
    e.cyc = c; e.nm = nm; e.rn = rn; e.ca = ca; e.rd = rd; e.st = st; e.llc = llc;
    sb.push_back(e);
  endtask

  task automatic push_acq(input int base, input string nm, input int llc);
    for (int i = 0; i < 7; i++)
      push(base + acq[i].off, nm, acq[i].rn, acq[i].ca, acq[i].rd, acq[i].st, llc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge hclkin);
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Scoreboard: compare every queued expectation whose cycle has arrived.
  always @(negedge hclkin) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        total++;
        if (clkdiv_resetn !== sb[i].rn || clkdiv_calib !== sb[i].ca ||
            div_ready !== sb[i].rd || state !== sb[i].st ||
            (sb[i].llc >= 0 && lock_lost_cnt !== 8'(sb[i].llc))) begin
          bad++;
          $display("FAIL %s @cyc %0d: got rn=%b ca=%b rd=%b st=%0d llc=%0d expected rn=%b ca=%b rd=%b st=%0d llc=%0d",
                   sb[i].nm, cyc, clkdiv_resetn, clkdiv_calib, div_ready, state, lock_lost_cnt,
                   sb[i].rn, sb[i].ca, sb[i].rd, sb[i].st, sb[i].llc);
        end
        sb.delete(i);
      end
    end
    if (!rst) begin
      total++;
      if (clkdiv_calib && !clkdiv_resetn) begin
        bad++;
        $display("FAIL calib_vs_resetn @cyc %0d: got calib=1 resetn=0 expected calib only with resetn=1", cyc);
      end
    end
  end

  initial begin
    int c;
    // Acquisition timeline relative to the edge before lock is first sampled high.
    acq[0] = '{2,  1'b0, 1'b0, 1'b0, 3'd0};
    acq[1] = '{9,  1'b0, 1'b0, 1'b0, 3'd0};
    acq[2] = '{10, 1'b0, 1'b0, 1'b0, 3'd1};
    acq[3] = '{13, 1'b0, 1'b0, 1'b0, 3'd1};
    acq[4] = '{14, 1'b1, 1'b0, 1'b0, 3'd2};
    acq[5] = '{17, 1'b1, 1'b0, 1'b0, 3'd2};
    acq[6] = '{18, 1'b1, 1'b0, 1'b1, 3'd3};
    cal[0] = '{3,  1'b1, 1'b0, 1'b1, 3'd3};
    cal[1] = '{4,  1'b1, 1'b1, 1'b0, 3'd4};
    cal[2] = '{5,  1'b1, 1'b1, 1'b0, 3'd4};
    cal[3] = '{6,  1'b1, 1'b0, 1'b0, 3'd2};
    cal[4] = '{9,  1'b1, 1'b0, 1'b0, 3'd2};
    cal[5] = '{10, 1'b1, 1'b0, 1'b1, 3'd3};

    rst = 1'b1; pll_lock = 1'b0; calib_req = 1'b0;
    #1;
    check_val("rst_resetn", clkdiv_resetn, 0);
    check_val("rst_calib", clkdiv_calib, 0);
    check_val("rst_ready", div_ready, 0);
    check_val("rst_state", state, 0);
    check_val("rst_llc", lock_lost_cnt, 0);
    step(5);
    rst = 1'b0;

    // 1. power-up acquisition
    step(1);
    pll_lock = 1'b1;
    push_acq(cyc, "pwrup", 0);
    step(20);

    // 2. lock glitch during qualification
    rst = 1'b1; pll_lock = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);
    pll_lock = 1'b1;
    step(5);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    push_acq(cyc, "glitch", 0);
    step(20);

    // 3. lock loss in READY, then relock
    pll_lock = 1'b0;
    c = cyc;
    push(c + 2, "drop_pre", 1'b1, 1'b0, 1'b1, 3'd3, 0);
    push(c + 3, "drop", 1'b0, 1'b0, 1'b0, 3'd0, 1);
    step(4);
    pll_lock = 1'b1;
    push_acq(cyc, "relock", 1);
    step(20);

    // 4. calibration with the request level held high
    calib_req = 1'b1;
    c = cyc;
    for (int i = 0; i < 6; i++)
      push(c + cal[i].off, "calib", cal[i].rn, cal[i].ca, cal[i].rd, cal[i].st, 1);
    for (int n = 11; n <= 20; n++)
      push(c + n, "no_repulse", 1'b1, 1'b0, 1'b1, 3'd3, 1);
    step(20);
    calib_req = 1'b0;
    step(4);

    // 5a. calibration edge landing in SETTLE is dropped
    pll_lock = 1'b0;
    step(4);
    pll_lock = 1'b1;
    c = cyc;
    push_acq(c, "settle_acq", 2);
    step(12);
    calib_req = 1'b1;
    for (int n = 19; n <= 26; n++)
      push(c + n, "settle_drop", 1'b1, 1'b0, 1'b1, 3'd3, 2);
    step(16);
    calib_req = 1'b0;
    step(4);

    // 5b. lock loss and calibration edge in the same cycle: lock loss wins
    calib_req = 1'b1;
    c = cyc;
    step(1);
    pll_lock = 1'b0;
    push(c + 3, "prio_pre", 1'b1, 1'b0, 1'b1, 3'd3, 2);
    for (int n = 4; n <= 8; n++)
      push(c + n, "prio", 1'b0, 1'b0, 1'b0, 3'd0, 3);
    step(8);
    calib_req = 1'b0;
    pll_lock = 1'b1;
    push_acq(cyc, "prio_relock", 3);
    step(20);

    // 6. asynchronous reset in the middle of CALIB
    calib_req = 1'b1;
    step(4);
    #2;
    check_val("calib_before_rst", clkdiv_calib, 1);
    rst = 1'b1;
    #1;
    check_val("arst_resetn", clkdiv_resetn, 0);
    check_val("arst_calib", clkdiv_calib, 0);
    check_val("arst_ready", div_ready, 0);
    check_val("arst_state", state, 0);
    check_val("arst_llc", lock_lost_cnt, 0);
    step(2);
    rst = 1'b0; calib_req = 1'b0; pll_lock = 1'b0;
    step(2);

    // lock-loss counter saturation
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      step(12);
      pll_lock = 1'b0;
      step(3);
      if (i == 9) check_val("llc_10", lock_lost_cnt, 10);
    end
    check_val("llc_sat", lock_lost_cnt, 255);
    check_val("sat_state", state, 0);

    step(2);
    check_val("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
